// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output stage: log2 sizing, bit reversal and
// the reorder reader state encoding.
package fft_pkg;

  localparam int MAX_NN = 12;

  typedef logic [MAX_NN-1:0] idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  function automatic int fft_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i <= MAX_NN; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int fft_nn(input int n);
    return fft_log2(n);
  endfunction

  // Reverses the low nn bits of v; bits at and above nn come back as zero.
  function automatic idx_t fft_bitrev(input idx_t v, input int nn);
    idx_t r;
    r = '0;
    for (int i = 0; i < MAX_NN; i++) begin
      if (i < nn) r[i] = v[nn-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
module fft_reorder_ram #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // The bank arbitration keeps reads and writes to one address apart, so no bypass.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_reorder.sv
// Ping-pong reorder buffer turning bit-reversed FFT frames into natural order.
// Optional output odata_sop (bin-0 marker) is enabled by FFT_REORDER_SOP_EN.
module fft_reorder
  import fft_pkg::*;
#(
  parameter int N     = 128,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             idata_en,
  input  logic [WIDTH-1:0] idata_r,
  input  logic [WIDTH-1:0] idata_i,
  output logic             odata_en,
  output logic [WIDTH-1:0] odata_r,
  output logic [WIDTH-1:0] odata_i
`ifdef FFT_REORDER_SOP_EN
  ,
  output logic             odata_sop
`endif
);

  localparam int NN = fft_nn(N);
  localparam int AW = NN + 1;

  logic [NN-1:0]      wcnt;
  logic               wbank;
  logic [1:0]         full, full_nxt;
  logic [NN-1:0]      wr_idx;
  logic               wr_last, we;

  rd_state_t          state, state_nxt;
  logic [NN-1:0]      rcnt, rcnt_nxt;
  logic               rbank, rbank_nxt;
  logic               rd_active, rd_last, rd_valid;
  logic [2*WIDTH-1:0] rdata;

  assign wr_idx  = NN'(fft_bitrev(idx_t'(wcnt), NN));
  assign wr_last = idata_en && (wcnt == NN'(N-1));
  assign we      = idata_en && !full[wbank];

  // A full bank with an idle reader starts reading in the same cycle, which
  // keeps the first output two edges after the frame's last input.
  assign rd_active = (state == READ) || full[rbank];
  assign rd_last   = rd_active && (rcnt == NN'(N-1));

  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    rbank_nxt = rbank;
    if (rd_active) begin
      rcnt_nxt  = rcnt + 1'b1;
      state_nxt = READ;
      if (rd_last) begin
        rbank_nxt = ~rbank;
        state_nxt = full[~rbank] ? READ : IDLE;
      end
    end
  end

  // A frame completing into a still-full bank is dropped.
  always_comb begin
    full_nxt = full;
    if (rd_last) full_nxt[rbank] = 1'b0;
    if (wr_last && !full[wbank]) full_nxt[wbank] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wcnt     <= '0;
      wbank    <= 1'b0;
      full     <= 2'b00;
      state    <= IDLE;
      rcnt     <= '0;
      rbank    <= 1'b0;
      rd_valid <= 1'b0;
      odata_en <= 1'b0;
      odata_r  <= '0;
      odata_i  <= '0;
    end else begin
      if (idata_en) wcnt <= wcnt + 1'b1;
      if (wr_last && !full[wbank]) wbank <= ~wbank;
      full     <= full_nxt;
      state    <= state_nxt;
      rcnt     <= rcnt_nxt;
      rbank    <= rbank_nxt;
      rd_valid <= rd_active;
      odata_en <= rd_valid;
      if (rd_valid) begin
        odata_r <= rdata[2*WIDTH-1:WIDTH];
        odata_i <= rdata[WIDTH-1:0];
      end
    end
  end

`ifdef FFT_REORDER_SOP_EN
  logic rd_sop;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_sop    <= 1'b0;
      odata_sop <= 1'b0;
    end else begin
      rd_sop    <= rd_active && (rcnt == '0);
      odata_sop <= rd_sop;
    end
  end
`endif

  fft_reorder_ram #(
    .DW(2*WIDTH),
    .AW(AW)
  ) u_ram (
    .clock(clock),
    .we   (we),
    .waddr({wbank, wr_idx}),
    .wdata({idata_r, idata_i}),
    .re   (rd_active),
    .raddr({rbank, rcnt}),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_fft_reorder.sv
// Directed bench for fft_reorder (N=128, WIDTH=16); define FFT_REORDER_SOP_EN
// to also exercise odata_sop.
module tb_fft_reorder;

  localparam int N = 128;
  localparam int W = 16;

  logic         clock;
  logic         reset;
  logic         idata_en;
  logic [W-1:0] idata_r;
  logic [W-1:0] idata_i;
  logic         odata_en;
  logic [W-1:0] odata_r;
  logic [W-1:0] odata_i;
`ifdef FFT_REORDER_SOP_EN
  logic         odata_sop;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W-1:0] out_r_q[$];
  logic [W-1:0] out_i_q[$];
  int           out_c_q[$];
`ifdef FFT_REORDER_SOP_EN
  int           sop_c_q[$];
  logic [W-1:0] sop_r_q[$];
  int           sop_stray = 0;
`endif

  fft_reorder #(.N(N), .WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .idata_en(idata_en),
    .idata_r (idata_r),
    .idata_i (idata_i),
    .odata_en(odata_en),
    .odata_r (odata_r),
    .odata_i (odata_i)
`ifdef FFT_REORDER_SOP_EN
    ,
    .odata_sop(odata_sop)
`endif
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // output monitor, sampled on the falling edge
  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (odata_en) begin
      out_r_q.push_back(odata_r);
      out_i_q.push_back(odata_i);
      out_c_q.push_back(cyc);
    end
`ifdef FFT_REORDER_SOP_EN
    if (odata_sop && odata_en) begin
      sop_c_q.push_back(cyc);
      sop_r_q.push_back(odata_r);
    end
    if (odata_sop && !odata_en) sop_stray <= sop_stray + 1;
`endif
  end

  function automatic logic [6:0] rev7(input logic [6:0] v);
    logic [6:0] r;
    for (int b = 0; b < 7; b++) r[b] = v[6-b];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_q();
    out_r_q.delete();
    out_i_q.delete();
    out_c_q.delete();
  endtask

  // Input position k carries bin rev7(k): r = base + bin, i = ~r.
  task automatic send_frame(input int base, input bit gapped, input int count);
    logic [W-1:0] r;
    for (int k = 0; k < count; k++) begin
      r = W'(base + int'(rev7(7'(k))));
      idata_en = 1'b1;
      idata_r  = r;
      idata_i  = ~r;
      step();
      if (gapped) begin
        idata_en = 1'b0;
        step();
      end
    end
    idata_en = 1'b0;
  endtask

  task automatic wait_count(input string tag, input int n, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (out_r_q.size() >= n) break;
      step();
    end
    chk({tag, "_timeout"}, 32'(i < budget), 32'd1);
    for (int j = 0; j < 8; j++) step();
  endtask

  // Frames appear consecutively, frame f carrying base + f*256 + m at bin m.
  task automatic check_frames(input string tag, input int base, input int nframes);
    int bad, first_bad, idx;
    logic [W-1:0] er;
    chk({tag, "_count"}, 32'(out_r_q.size()), 32'(nframes * N));
    if (out_r_q.size() == nframes * N) begin
      chk({tag, "_contig"}, 32'(out_c_q[nframes*N-1] - out_c_q[0]), 32'(nframes*N - 1));
      for (int f = 0; f < nframes; f++) begin
        bad = 0;
        first_bad = -1;
        for (int m = 0; m < N; m++) begin
          idx = f * N + m;
          er  = W'(base + f * 256 + m);
          if (out_r_q[idx] !== er || out_i_q[idx] !== ~er) begin
            bad++;
            if (first_bad < 0) first_bad = m;
          end
        end
        chk($sformatf("%s_frame%0d_bad_samples(first_bin=%0d)", tag, f, first_bad),
            32'(bad), 32'd0);
      end
    end
  endtask

  initial begin
    reset    = 1'b0;
    idata_en = 1'b0;
    idata_r  = '0;
    idata_i  = '0;
    step();
    step();
    step();
    chk("reset_en", 32'(odata_en), 32'd0);
    chk("reset_r", 32'(odata_r), 32'd0);
    chk("reset_i", 32'(odata_i), 32'd0);
    reset = 1'b1;
    step();

    // 1: index frame and first-output latency
    clear_q();
    send_frame(0, 1'b0, N);
    chk("lat_e0", 32'(odata_en), 32'd0);
    step();
    chk("lat_e1", 32'(odata_en), 32'd0);
    step();
    chk("lat_e2", 32'(odata_en), 32'd1);
    wait_count("s1", N, 400);
    check_frames("s1", 0, 1);
    if (out_r_q.size() >= 65) begin
      chk("s1_m1_r", 32'(out_r_q[1]), 32'h0001);
      chk("s1_m1_i", 32'(out_i_q[1]), 32'hFFFE);
      chk("s1_m64_r", 32'(out_r_q[64]), 32'h0040);
      chk("s1_m64_i", 32'(out_i_q[64]), 32'hFFBF);
    end
    chk("s1_hold_en", 32'(odata_en), 32'd0);
    chk("s1_hold_r", 32'(odata_r), 32'h007F);
    chk("s1_hold_i", 32'(odata_i), 32'hFF80);

    // 2: four back-to-back frames
    clear_q();
    for (int f = 0; f < 4; f++) send_frame(32'h100 * (f + 1), 1'b0, N);
    wait_count("s2", 4 * N, 800);
    check_frames("s2", 32'h100, 4);

    // 3: gapped input
    clear_q();
    send_frame(0, 1'b1, N);
    wait_count("s3", N, 400);
    check_frames("s3", 0, 1);

    // 4: reset after 60 input samples, then a fresh frame
    clear_q();
    send_frame(32'h700, 1'b0, 60);
    reset = 1'b0;
    step();
    chk("s4_rst_en", 32'(odata_en), 32'd0);
    reset = 1'b1;
    for (int j = 0; j < 5; j++) step();
    chk("s4_idle_en", 32'(odata_en), 32'd0);
    send_frame(32'h500, 1'b0, N);
    chk("s4_no_early_out", 32'(out_r_q.size()), 32'd0);
    wait_count("s4", N, 400);
    check_frames("s4", 32'h500, 1);

    // 5: reset ten samples into an output burst
    clear_q();
    send_frame(32'h600, 1'b0, N);
    for (int j = 0; j < 100; j++) begin
      @(negedge clock);
      #1;
      if (out_r_q.size() >= 10) break;
    end
    chk("s5_started", 32'(out_r_q.size()), 32'd10);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("s5_rst_en", 32'(odata_en), 32'd0);
    chk("s5_rst_r", 32'(odata_r), 32'd0);
    chk("s5_rst_i", 32'(odata_i), 32'd0);
    reset = 1'b1;
    for (int j = 0; j < 200; j++) step();
    chk("s5_no_more_out", 32'(out_r_q.size()), 32'd10);
    clear_q();
    send_frame(32'h800, 1'b0, N);
    wait_count("s5", N, 400);
    check_frames("s5", 32'h800, 1);

`ifdef FFT_REORDER_SOP_EN
    // 6: start-of-frame marker over two back-to-back frames
    clear_q();
    sop_c_q.delete();
    sop_r_q.delete();
    send_frame(32'h900, 1'b0, N);
    send_frame(32'hA00, 1'b0, N);
    wait_count("s6", 2 * N, 600);
    check_frames("s6", 32'h900, 2);
    chk("sop_count", 32'(sop_c_q.size()), 32'd2);
    chk("sop_stray", 32'(sop_stray), 32'd0);
    if (sop_c_q.size() == 2 && out_c_q.size() > 0) begin
      chk("sop_first_cyc", 32'(sop_c_q[0] - out_c_q[0]), 32'd0);
      chk("sop_spacing", 32'(sop_c_q[1] - sop_c_q[0]), 32'd128);
      chk("sop0_r", 32'(sop_r_q[0]), 32'h0900);
      chk("sop1_r", 32'(sop_r_q[1]), 32'h0A00);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
